// File: rtl/uart_rx_mode1.sv
// 8051 mode-1 UART receiver: 16x oversampling,
// 7/8/9 majority vote, SBUF/RB8/RI load logic.
module uart_rx_mode1 #(
  parameter int unsigned DIV = 78
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ren,
  input  logic       sm2,
  input  logic       ri_clr,
  output logic [7:0] sbuf,
  output logic       rb8,
  output logic       ri,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  localparam logic [7:0] DLAST = 8'(DIV - 1);

  state_t     state, state_nx;
  logic       s1, rxs, rxs_d;
  logic       fall, start_det;
  logic [7:0] div_cnt;
  logic       tick;
  logic [3:0] smp;
  logic [1:0] vote;
  logic       maj;
  logic       at9, at15;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       shift_en, bit_inc, eval;
  logic       load;

  assign fall      = rxs_d & ~rxs;
  assign start_det = (state == IDLE) & ren & fall;
  assign tick      = (div_cnt == DLAST);
  assign at9       = tick & (smp == 4'd9);
  assign at15      = tick & (smp == 4'd15);
  assign maj       = (vote[0] & vote[1]) |
                     (vote[0] & rxs) |
                     (vote[1] & rxs);
  assign load      = eval & ~ri & (~sm2 | maj);
  assign busy      = (state != IDLE);

  // two-flop synchronizer plus delayed copy for edge detect
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rxd;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end

  // oversample divider, realigned to the start edge
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // sample index within the current bit
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      smp <= '0;
    end else if (start_det) begin
      smp <= '0;
    end else if (tick) begin
      smp <= smp + 4'd1;
    end
  end

  // capture samples 7 and 8; sample 9 is taken live
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      vote <= '0;
    end else if (tick && smp == 4'd7) begin
      vote[0] <= rxs;
    end else if (tick && smp == 4'd8) begin
      vote[1] <= rxs;
    end
  end

  // data bit counter and LSB-first shift register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (start_det) begin
        bitcnt <= '0;
      end else if (bit_inc) begin
        bitcnt <= bitcnt + 3'd1;
      end
      if (shift_en) begin
        shreg <= {maj, shreg[7:1]};
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state and per-sample control strobes
  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    bit_inc  = 1'b0;
    eval     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_det) begin
          state_nx = START;
        end
      end
      START: begin
        if (at9 && maj) begin
          state_nx = IDLE;
        end else if (at15) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (at9) begin
          shift_en = 1'b1;
        end
        if (at15) begin
          bit_inc = 1'b1;
          if (bitcnt == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (at9) begin
          eval     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // SBUF/RB8 load; set of a flag wins over software clear
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sbuf      <= '0;
      rb8       <= 1'b0;
      ri        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        sbuf <= shreg;
        rb8  <= maj;
      end
      if (load) begin
        ri <= 1'b1;
      end else if (ri_clr) begin
        ri <= 1'b0;
      end
      if (eval && !maj) begin
        frame_err <= 1'b1;
      end else if (ri_clr) begin
        frame_err <= 1'b0;
      end
      if (eval && ri) begin
        overrun <= 1'b1;
      end else if (ri_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mode1.sv
// Directed bench for uart_rx_mode1 with DIV=4
// and a queue of expected post-frame register states.
module tb_uart_rx_mode1;

  logic       CLK = 1'b0;
  logic       reset;
  logic       rxd;
  logic       ren;
  logic       sm2;
  logic       ri_clr;
  logic [7:0] sbuf;
  logic       rb8;
  logic       ri;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_mode1 #(.DIV(4)) dut (
    .CLK(CLK),
    .reset(reset),
    .rxd(rxd),
    .ren(ren),
    .sm2(sm2),
    .ri_clr(ri_clr),
    .sbuf(sbuf),
    .rb8(rb8),
    .ri(ri),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] sbuf;
    logic       rb8;
    logic       ri;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int lat = -1;
  int busy_cnt = 0;
  logic ri_q = 1'b0;

  logic [7:0] m_sbuf;
  logic       m_rb8, m_ri, m_fe, m_ov;

  always @(posedge CLK) cyc <= cyc + 1;

  // latency of each ri rise and a count of busy cycles
  always @(negedge CLK) begin
    ri_q <= ri;
    if (ri && !ri_q) lat <= cyc - t0;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sbuf = 8'h00;
    m_rb8  = 1'b0;
    m_ri   = 1'b0;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d,
                             input logic stop);
    if (m_ri) begin
      m_ov = 1'b1;
    end else if (!sm2 || stop) begin
      m_sbuf = d;
      m_rb8  = stop;
      m_ri   = 1'b1;
    end
    if (!stop) m_fe = 1'b1;
    q.push_back('{m_sbuf, m_rb8, m_ri, m_fe, m_ov});
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop);
    rxd = 1'b0;
    t0  = cyc;
    repeat (64) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (64) @(negedge CLK);
    end
    rxd = stop;
    repeat (64) @(negedge CLK);
    rxd = 1'b1;
    repeat (16) @(negedge CLK);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    tests++;
    assert (q.size() != 0) else begin
      fails++;
      $error("FAIL %s.queue: observed empty expected entry",
             tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".sbuf"}, 32'(sbuf), 32'(e.sbuf));
      chk({tag, ".rb8"}, 32'(rb8), 32'(e.rb8));
      chk({tag, ".ri"}, 32'(ri), 32'(e.ri));
      chk({tag, ".fe"}, 32'(frame_err), 32'(e.fe));
      chk({tag, ".ov"}, 32'(overrun), 32'(e.ov));
      chk({tag, ".busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] d,
                       input logic stop);
    model_frame(d, stop);
    send_frame(d, stop);
    check_sb(tag);
  endtask

  task automatic clear_ri(input string tag);
    ri_clr = 1'b1;
    @(negedge CLK);
    ri_clr = 1'b0;
    m_ri = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    chk({tag, ".ri"}, 32'(ri), 32'd0);
    chk({tag, ".fe"}, 32'(frame_err), 32'd0);
    chk({tag, ".ov"}, 32'(overrun), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sbuf"}, 32'(sbuf), 32'h00);
    chk({tag, ".rb8"}, 32'(rb8), 32'd0);
    chk({tag, ".ri"}, 32'(ri), 32'd0);
    chk({tag, ".fe"}, 32'(frame_err), 32'd0);
    chk({tag, ".ov"}, 32'(overrun), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int b0;
    logic [7:0] d96;
    reset  = 1'b1;
    rxd    = 1'b1;
    ren    = 1'b0;
    sm2    = 1'b0;
    ri_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_reset_vals("rst");
    reset = 1'b0;
    ren   = 1'b1;
    repeat (4) @(negedge CLK);

    frame("a5", 8'hA5, 1'b1);
    chk("a5.lat", 32'(lat), 32'd619);

    frame("ovr", 8'h3C, 1'b1);
    clear_ri("clr1");
    frame("3c", 8'h3C, 1'b1);
    chk("3c.lat", 32'(lat), 32'd619);
    clear_ri("clr2");

    rxd = 1'b0;
    repeat (10) @(negedge CLK);
    chk("glitch.busy_hi", 32'(busy), 32'd1);
    repeat (10) @(negedge CLK);
    rxd = 1'b1;
    repeat (30) @(negedge CLK);
    chk("glitch.busy_lo", 32'(busy), 32'd0);
    chk("glitch.ri", 32'(ri), 32'd0);
    chk("glitch.sbuf", 32'(sbuf), 32'h3C);
    frame("81", 8'h81, 1'b1);
    clear_ri("clr3");

    sm2 = 1'b1;
    frame("sm2", 8'h55, 1'b0);
    sm2 = 1'b0;
    frame("55", 8'h55, 1'b0);
    clear_ri("clr4");

    b0  = busy_cnt;
    ren = 1'b0;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (200) @(negedge CLK);
        ren = 1'b1;
      end
    join
    chk("ren.busy", 32'(busy_cnt - b0), 32'd0);
    chk("ren.ri", 32'(ri), 32'd0);
    chk("ren.sbuf", 32'(sbuf), 32'h55);

    d96 = 8'h96;
    rxd = 1'b0;
    repeat (64) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      rxd = d96[i];
      repeat (64) @(negedge CLK);
    end
    rxd = d96[3];
    repeat (32) @(negedge CLK);
    chk("mid.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(negedge CLK);
    chk_reset_vals("rst2");
    model_reset();
    reset = 1'b0;
    repeat (16) @(negedge CLK);
    frame("96", 8'h96, 1'b1);
    clear_ri("clr5");

    model_frame(8'h5A, 1'b1);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (618) @(negedge CLK);
        ri_clr = 1'b1;
        @(negedge CLK);
        ri_clr = 1'b0;
      end
    join
    check_sb("race");
    chk("race.lat", 32'(lat), 32'd619);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
